// File: rtl/serial_rxd.sv
// serial_rxd: 8N1 UART receiver with an 8-entry receive FIFO and a WISHBONE read port.
// The line is synchronised, the start bit is re-checked at mid-bit, and each bit is sampled mid-bit.
// Completed bytes are pushed into the FIFO one cycle after the stop-bit sample.
module serial_rxd #(
    parameter logic [9:0] one_bit  = 10'd260,
    parameter logic [9:0] half_bit = 10'd130
) (
    input  logic       clk_30,
    input  logic       reset_n,
    input  logic       CYC_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic [7:0] DAT_O,
    output logic       ACK_O,
    input  logic       uart_rxd,
    output logic       uart_rts,
    output logic       overrun,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic       rxd_meta_r;
    logic       rxd_s;
    state_t     state_r;
    state_t     state_nxt_s;
    logic [9:0] cnt_r;
    logic [2:0] idx_r;
    logic [7:0] shift_r;
    logic       push_r;
    logic       frame_err_r;
    logic       overrun_r;

    logic       half_hit_s;
    logic       bit_hit_s;
    logic       cnt_clr_s;
    logic       idx_clr_s;
    logic       sample_s;
    logic       push_set_s;
    logic       frame_set_s;

    logic [7:0] mem_r [8];
    logic [2:0] wptr_r;
    logic [2:0] rptr_r;
    logic [3:0] count_r;
    logic       ack_r;
    logic [7:0] dat_r;
    logic       rts_r;

    logic       req_s;
    logic       pop_s;
    logic       full_s;
    logic       wr_s;
    logic       ovf_s;

    assign half_hit_s = (cnt_r == (half_bit - 10'd1));
    assign bit_hit_s  = (cnt_r == (one_bit - 10'd1));

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_r <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_s      <= rxd_meta_r;
        end
    end

    // Receive FSM state register.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Receive FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rxd_s) state_nxt_s = ST_START;
                else        state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (half_hit_s) state_nxt_s = rxd_s ? ST_IDLE : ST_DATA;
                else            state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (bit_hit_s && (idx_r == 3'd7)) state_nxt_s = ST_STOP;
                else                              state_nxt_s = ST_DATA;
            end
            ST_STOP: begin
                if (bit_hit_s) state_nxt_s = rxd_s ? ST_IDLE : ST_BREAK;
                else           state_nxt_s = ST_STOP;
            end
            ST_BREAK: begin
                if (rxd_s) state_nxt_s = ST_IDLE;
                else       state_nxt_s = ST_BREAK;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Receive FSM control strobes for the bit counter, shifter and status flags.
    always_comb begin
        cnt_clr_s   = 1'b0;
        idx_clr_s   = 1'b0;
        sample_s    = 1'b0;
        push_set_s  = 1'b0;
        frame_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                idx_clr_s = 1'b1;
            end
            ST_START: begin
                cnt_clr_s = half_hit_s;
                idx_clr_s = half_hit_s;
            end
            ST_DATA: begin
                cnt_clr_s = bit_hit_s;
                sample_s  = bit_hit_s;
            end
            ST_STOP: begin
                cnt_clr_s   = bit_hit_s;
                push_set_s  = bit_hit_s & rxd_s;
                frame_set_s = bit_hit_s & ~rxd_s;
            end
            ST_BREAK: begin
                cnt_clr_s = 1'b1;
                idx_clr_s = 1'b1;
            end
            default: begin
                cnt_clr_s = 1'b1;
                idx_clr_s = 1'b1;
            end
        endcase
    end

    // Bit-timing counter, bit index, shift register, push request and framing flag.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r       <= 10'd0;
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_clr_s ? 10'd0 : (cnt_r + 10'd1);
            if (idx_clr_s) begin
                idx_r <= 3'd0;
            end else if (sample_s) begin
                idx_r          <= idx_r + 3'd1;
                shift_r[idx_r] <= rxd_s;
            end else begin
                idx_r <= idx_r;
            end
            push_r      <= push_set_s;
            frame_err_r <= frame_err_r | frame_set_s;
        end
    end

    // A read pops only when data is present; a write is acknowledged without effect.
    assign req_s  = CYC_I & STB_I & ~ack_r;
    assign pop_s  = req_s & ~WE_I & (count_r != 4'd0);
    assign full_s = (count_r == 4'd8);
    assign wr_s   = push_r & (~full_s | pop_s);
    assign ovf_s  = push_r & full_s & ~pop_s;

    // Receive FIFO storage, pointers, occupancy and overrun flag.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            mem_r     <= '{default: 8'h00};
            wptr_r    <= 3'd0;
            rptr_r    <= 3'd0;
            count_r   <= 4'd0;
            overrun_r <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_r[wptr_r] <= shift_r;
                wptr_r        <= wptr_r + 3'd1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 3'd1;
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
            overrun_r <= overrun_r | ovf_s;
        end
    end

    // Bus acknowledge, read data and flow-control output registers.
    always_ff @(posedge clk_30 or negedge reset_n) begin
        if (!reset_n) begin
            ack_r <= 1'b0;
            dat_r <= 8'h00;
            rts_r <= 1'b1;
        end else begin
            ack_r <= req_s & (WE_I | (count_r != 4'd0));
            if (pop_s) begin
                dat_r <= mem_r[rptr_r];
            end
            rts_r <= (count_r <= 4'd5);
        end
    end

    assign DAT_O     = dat_r;
    assign ACK_O     = ack_r;
    assign uart_rts  = rts_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_serial_rxd.sv
// Testbench for serial_rxd: directed scenarios plus randomized frames and reads,
// checked against a queue-based model of the receive FIFO and sticky flags.
module tb_serial_rxd;

    logic       clk_30;
    logic       reset_n;
    logic       CYC_I;
    logic       STB_I;
    logic       WE_I;
    logic [7:0] DAT_O;
    logic       ACK_O;
    logic       uart_rxd;
    logic       uart_rts;
    logic       overrun;
    logic       frame_err;

    int         n_cmp;
    int         n_err;

    // state captured while a frame is being transmitted
    int         ack_first;
    int         ack_cnt;
    logic [7:0] ack_dat;

    // reference model
    logic [7:0] q[$];
    logic       exp_ovr;
    logic       exp_ferr;

    localparam int BIT = 260;

    serial_rxd dut (
        .clk_30    (clk_30),
        .reset_n   (reset_n),
        .CYC_I     (CYC_I),
        .STB_I     (STB_I),
        .WE_I      (WE_I),
        .DAT_O     (DAT_O),
        .ACK_O     (ACK_O),
        .uart_rxd  (uart_rxd),
        .uart_rts  (uart_rts),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial begin
        clk_30 = 1'b0;
        forever #5 clk_30 = ~clk_30;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_30);
    endtask

    // Transmit one 8N1 frame LSB first; watches ACK_O on every cycle of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        int k;
        bits      = {stop, b, 1'b0};
        ack_first = 0;
        ack_cnt   = 0;
        ack_dat   = 8'h00;
        k         = 0;
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (BIT) begin
                @(negedge clk_30);
                k++;
                if (ACK_O === 1'b1) begin
                    ack_cnt++;
                    if (ack_first == 0) begin
                        ack_first = k;
                        ack_dat   = DAT_O;
                    end
                end
            end
        end
    endtask

    task automatic do_read(input logic [7:0] exp, input string tag);
        int w;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        w     = 0;
        do begin
            @(negedge clk_30);
            w++;
        end while ((ACK_O !== 1'b1) && (w < 40));
        check({tag, " ack"}, 32'(ACK_O), 32'd1);
        check({tag, " dat"}, 32'(DAT_O), 32'(exp));
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge clk_30);
        check({tag, " pulse"}, 32'(ACK_O), 32'd0);
    endtask

    task automatic do_write(input string tag);
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b1;
        @(negedge clk_30);
        check({tag, " wr ack"}, 32'(ACK_O), 32'd1);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        @(negedge clk_30);
        check({tag, " wr pulse"}, 32'(ACK_O), 32'd0);
    endtask

    // A read against an empty FIFO must stall without any acknowledge.
    task automatic check_empty(input string tag);
        int seen;
        seen  = 0;
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        repeat (20) begin
            @(negedge clk_30);
            if (ACK_O === 1'b1) seen++;
        end
        CYC_I = 1'b0;
        STB_I = 1'b0;
        check({tag, " empty"}, 32'(seen), 32'd0);
        @(negedge clk_30);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ACK_O"},     32'(ACK_O),     32'd0);
        check({tag, " DAT_O"},     32'(DAT_O),     32'h00);
        check({tag, " uart_rts"},  32'(uart_rts),  32'd1);
        check({tag, " overrun"},   32'(overrun),   32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int nf;
        int nr;
        logic [7:0] b;
        logic bad;

        n_cmp    = 0;
        n_err    = 0;
        reset_n  = 1'b1;
        CYC_I    = 1'b0;
        STB_I    = 1'b0;
        WE_I     = 1'b0;
        uart_rxd = 1'b1;
        #2;
        reset_n = 1'b0;
        idle(3);
        check_reset_vals("reset");
        reset_n = 1'b1;
        idle(5);

        // Frame 0xA5, then read; FIFO empty afterwards.
        send_frame(8'hA5, 1'b1);
        idle(10);
        do_read(8'hA5, "a5");
        check_empty("a5 after");

        // Short low glitch is rejected.
        uart_rxd = 1'b0;
        idle(100);
        uart_rxd = 1'b1;
        idle(300);
        check("glitch frame_err", 32'(frame_err), 32'd0);
        check_empty("glitch");

        // Low stop bit then a long break.
        send_frame(8'h3C, 1'b0);
        idle(1000);
        check("break frame_err", 32'(frame_err), 32'd1);
        check_empty("break");
        uart_rxd = 1'b1;
        idle(20);
        send_frame(8'h42, 1'b1);
        idle(10);
        do_read(8'h42, "after break");
        check("break sticky", 32'(frame_err), 32'd1);

        // Read held with an empty FIFO while frame 0x5A arrives.
        CYC_I = 1'b1;
        STB_I = 1'b1;
        WE_I  = 1'b0;
        send_frame(8'h5A, 1'b1);
        CYC_I = 1'b0;
        STB_I = 1'b0;
        check("stall ack count", 32'(ack_cnt), 32'd1);
        check("stall ack timing", 32'((ack_first >= 2465) && (ack_first <= 2485)), 32'd1);
        check("stall dat", 32'(ack_dat), 32'h5A);
        idle(10);

        // Nine frames without reads: flow control and overrun.
        for (int j = 1; j <= 9; j++) begin
            send_frame(8'(j), 1'b1);
            idle(10);
            check("fill rts", 32'(uart_rts), 32'(j <= 5));
            check("fill overrun", 32'(overrun), 32'(j == 9));
        end
        do_write("full");
        for (int j = 1; j <= 8; j++) begin
            do_read(8'(j), "drain");
        end
        check_empty("drain");
        check("drain rts", 32'(uart_rts), 32'd1);

        // Reset during bit 4 of frame 0xFF with a byte already queued.
        send_frame(8'h77, 1'b1);
        idle(10);
        uart_rxd = 1'b0;
        idle(BIT);
        uart_rxd = 1'b1;
        idle(4 * BIT + 130);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid reset");
        idle(5);
        reset_n = 1'b1;
        idle(130 + 4 * BIT);
        check_reset_vals("post reset");
        check_empty("post reset");
        send_frame(8'h81, 1'b1);
        idle(10);
        do_read(8'h81, "x81");

        // Randomized frames and reads against the queue model.
        q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        for (int r = 0; r < 3; r++) begin
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                b   = 8'($urandom);
                bad = ($urandom_range(0, 3) == 0);
                send_frame(b, ~bad);
                if (bad) begin
                    exp_ferr = 1'b1;
                    idle(300);
                    uart_rxd = 1'b1;
                    idle(20);
                end else begin
                    if (q.size() == 8) exp_ovr = 1'b1;
                    else               q.push_back(b);
                    idle(20);
                end
                check("rand rts", 32'(uart_rts), 32'(q.size() <= 5));
            end
            if ($urandom_range(0, 1) == 1) do_write("rand");
            nr = $urandom_range(0, q.size());
            for (int i = 0; i < nr; i++) begin
                do_read(q.pop_front(), "rand");
            end
        end
        check("rand overrun", 32'(overrun), 32'(exp_ovr));
        check("rand frame_err", 32'(frame_err), 32'(exp_ferr));
        while (q.size() > 0) begin
            do_read(q.pop_front(), "rand drain");
        end
        check_empty("rand end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
